vlane_load_wb: RTL and testbench
================================

VLANE_LOAD_WB -- requirements
Module: vlane_load_wb

Interface
REQ-001 SHALL have parameter Depth, default 2, meaning entry-FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter tx_lane_t, default logic, meaning lane beat type {reqId, vaddr_set, vaddr_bank, data[DLEN], nbe[DLEN/4]}.
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  the only clock.
- rst_i  in  1  asynchronous active-high reset.
- rx_valid_i  in  1  lane beat valid from shuffle stage.
- rx_ready_o  out  1  beat accepted.
- rx_i  in  tx_lane_t  lane beat.
- vrf_req_valid_o  out  1  VRF request valid.
- vrf_req_ready_i  in  1  VRF request accepted.
- vrf_req_we_o  out  1  1=write, 0=read.
- vrf_req_set_o  out  VAddrBits-VAddrBankBits  set address.
- vrf_req_bank_o  out  VAddrBankBits  bank address.
- vrf_req_wdata_o  out  DLEN  write data.
- vrf_req_be_o  out  DLEN/8  byte enables.
- vrf_rvalid_i  in  1  read data valid.
- vrf_rdata_i  in  DLEN  read data.
- cmt_valid_o  out  1  one-cycle pulse per retired beat.
- cmt_reqid_o  out  reqId width  reqId of retired beat.

Function
REQ-004 SHALL buffer beats in a Depth-entry FIFO; rx_ready_o = !full, with no bypass; a push and a pop in the same cycle are both honoured.
REQ-005 SHALL classify the FIFO head:
- NULL: nbe == 0.
- FULL: every byte has both nibble enables equal.
- PART: otherwise.
REQ-006 SHALL implement FSM states IDLE, RD_WAIT and WR; the reset state is IDLE.
REQ-007 IDLE with head NULL SHALL pop the head with no VRF request and pulse cmt in the same cycle.
REQ-008 IDLE with head FULL SHALL drive a combinational write:
- we=1, be[b] = nbe[2b] & nbe[2b+1], wdata = head.data.
- On handshake: pop, pulse cmt, stay IDLE. Back-to-back FULL beats sustain one write per cycle.
REQ-009 IDLE with head PART SHALL issue a read (we=0, be=0) at {vaddr_set, vaddr_bank}; on handshake go to RD_WAIT.
REQ-010 RD_WAIT SHALL deassert vrf_req_valid_o.
- On vrf_rvalid_i, register merged nibble n = nbe[n] ? head.data : rdata, then go to WR.
- Read latency is unbounded, minimum 1 cycle.
REQ-011 WR SHALL hold a write with the merged data and be[b] = nbe[2b] | nbe[2b+1]; on handshake: pop, pulse cmt, go to IDLE.
REQ-012 vrf_rvalid_i outside RD_WAIT SHALL be ignored.
REQ-013 vrf_req_* SHALL stay stable while valid and not ready.
REQ-014 cmt_valid_o SHALL be combinational with the pop; cmt_reqid_o = head.reqId, otherwise 0.
REQ-015 Empty FIFO in IDLE SHALL hold vrf_req_valid_o=0.

Reset
REQ-016 rst_i SHALL asynchronously empty the FIFO (pointers and wrap flags = 0) and force IDLE.
REQ-017 While rst_i is asserted or after reset, all outputs SHALL be 0 except rx_ready_o=1.
REQ-018 Reset mid-RMW SHALL abandon the beat without cmt; a late vrf_rvalid_i is ignored.

Configuration
REQ-019 Macro VLSU_LOAD_RMW_EN defined SHALL enable RMW: PART handled per REQ-009 to REQ-011.
REQ-020 Macro VLSU_LOAD_RMW_EN undefined SHALL remove RD_WAIT/WR and the merge register, and no read is ever issued.
- PART is treated as FULL but with be[b] = nbe[2b] | nbe[2b+1] and unmerged head.data.

Structure
REQ-021 The FSM state enum and the head-class enum SHALL live in vlsu_pkg.
REQ-022 VAddrBits, VAddrBankBits and DLEN SHALL come from vlsu_pkg / riva_pkg.
REQ-023 Enqueue and dequeue pointers SHALL be two CircularQueuePtrTemplate #(.ENTRIES(Depth)) instances; full/empty come from value equality plus flag comparison.

Verification
REQ-024 The bench SHALL use DLEN=64 and cover:
- FULL beat nbe=16'hFFFF, data=64'h0123_4567_89AB_CDEF, ready=1 -> write the same cycle, be=8'hFF, cmt pulse with reqId.
- PART beat nbe=16'h0001, data nibble0=4'hA, rdata=64'h1111_1111_1111_1111 -> read, then write 64'h1111_1111_1111_111A with be=8'h01; 1 cmt.
- NULL beat nbe=0 -> no VRF request; cmt pulse in the cycle it reaches the head.
- Depth=2, vrf_req_ready_i=0, three beats offered -> rx_ready_o=0 after two; release -> in-order retirement, pointers wrap correctly.
- rst_i asserted in RD_WAIT, then vrf_rvalid_i next cycle -> no write, no cmt, FIFO empty.
- VLSU_LOAD_RMW_EN undefined with PART nbe=16'h0001 -> single write with be=8'h01, vrf_req_we_o never 0.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared types and helpers for the vector load write-back lane.
// Provides the VRF geometry (DLEN, VAddrBits, VAddrBankBits), the lane beat
// payload, the write-back FSM state enum, and the head-class enum. It also
// provides the nibble-enable to byte-enable and merge helper functions.
package vlsu_pkg;

    localparam int unsigned DLEN          = 64;
    localparam int unsigned VAddrBits     = 12;
    localparam int unsigned VAddrBankBits = 2;
    localparam int unsigned VAddrSetBits  = VAddrBits - VAddrBankBits;
    localparam int unsigned ReqIdBits     = 4;
    localparam int unsigned NbeBits       = DLEN / 4;
    localparam int unsigned BeBits        = DLEN / 8;

    typedef struct packed {
        logic [ReqIdBits-1:0]     req_id;
        logic [VAddrSetBits-1:0]  vaddr_set;
        logic [VAddrBankBits-1:0] vaddr_bank;
        logic [DLEN-1:0]          data;
        logic [NbeBits-1:0]       nbe;
    } lane_beat_t;

    localparam int unsigned LaneBits = $bits(lane_beat_t);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } ld_state_e;

    typedef enum logic [1:0] {
        CLS_NULL = 2'd0,
        CLS_FULL = 2'd1,
        CLS_PART = 2'd2
    } head_class_e;

    // Byte enable set only where both nibbles of the byte are enabled.
    function automatic logic [BeBits-1:0] be_all(input logic [NbeBits-1:0] nbe);
        logic [BeBits-1:0] be;
        be = '0;
        for (int b = 0; b < BeBits; b++) begin
            be[b] = nbe[2*b] & nbe[2*b+1];
        end
        return be;
    endfunction

    // Byte enable set where either nibble of the byte is enabled.
    function automatic logic [BeBits-1:0] be_any(input logic [NbeBits-1:0] nbe);
        logic [BeBits-1:0] be;
        be = '0;
        for (int b = 0; b < BeBits; b++) begin
            be[b] = nbe[2*b] | nbe[2*b+1];
        end
        return be;
    endfunction

    // A beat is FULL when no byte has exactly one nibble enabled.
    function automatic head_class_e classify_head(input logic [NbeBits-1:0] nbe);
        head_class_e cls;
        if (nbe == '0) begin
            cls = CLS_NULL;
        end else if (be_all(nbe) == be_any(nbe)) begin
            cls = CLS_FULL;
        end else begin
            cls = CLS_PART;
        end
        return cls;
    endfunction

    // Enabled nibbles from the beat, all others from the VRF read data.
    function automatic logic [DLEN-1:0] merge_nibbles(input logic [NbeBits-1:0] nbe,
                                                      input logic [DLEN-1:0]    wdata,
                                                      input logic [DLEN-1:0]    rdata);
        logic [DLEN-1:0] m;
        m = '0;
        for (int n = 0; n < NbeBits; n++) begin
            m[4*n +: 4] = nbe[n] ? wdata[4*n +: 4] : rdata[4*n +: 4];
        end
        return m;
    endfunction

endpackage

// File: rtl/CircularQueuePtrTemplate.sv
// Circular queue pointer: an index into an ENTRIES-deep ring plus a wrap flag
// that toggles each time the index rolls over. ENTRIES must be a power of two.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (value and flag to 0)
//   incr_i   advance the pointer by one
//   value_o  current index
//   flag_o   wrap flag
module CircularQueuePtrTemplate #(
    parameter int unsigned ENTRIES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       incr_i,
    output logic [$clog2(ENTRIES)-1:0] value_o,
    output logic                       flag_o
);

    localparam int unsigned IdxBits = $clog2(ENTRIES);

    // Index wraps naturally at a power-of-two depth; flag flips on rollover.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_o <= '0;
            flag_o  <= 1'b0;
        end else if (incr_i) begin
            value_o <= IdxBits'(value_o + 1'b1);
            if (value_o == IdxBits'(ENTRIES - 1)) begin
                flag_o <= ~flag_o;
            end
        end
    end

endmodule

// File: rtl/vlane_load_wb.sv
// Vector load lane write-back. Lane beats from the shuffle stage are queued in
// a Depth-entry FIFO. Each head beat is retired to the VRF according to its
// nibble enables:
//   NULL  - no enables: retired with no VRF access.
//   FULL  - whole bytes only: written in a single cycle.
//   PART  - split bytes: read-modify-write when VLSU_LOAD_RMW_EN is defined;
//           otherwise written directly with any-nibble byte enables.
// Build option: VLSU_LOAD_RMW_EN (defined = RMW path with RD_WAIT/WR states).
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   rx_valid_i/rx_ready_o    beat handshake, rx_i beat payload (tx_lane_t)
//   vrf_req_*                VRF request (valid/ready, we, set, bank, wdata, be)
//   vrf_rvalid_i/rdata_i     VRF read response
//   cmt_valid_o/cmt_reqid_o  one-cycle retire pulse with the beat reqId
module vlane_load_wb
    import vlsu_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter type         tx_lane_t = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_valid_i,
    output logic                     rx_ready_o,
    input  tx_lane_t                 rx_i,
    output logic                     vrf_req_valid_o,
    input  logic                     vrf_req_ready_i,
    output logic                     vrf_req_we_o,
    output logic [VAddrSetBits-1:0]  vrf_req_set_o,
    output logic [VAddrBankBits-1:0] vrf_req_bank_o,
    output logic [DLEN-1:0]          vrf_req_wdata_o,
    output logic [BeBits-1:0]        vrf_req_be_o,
    input  logic                     vrf_rvalid_i,
    input  logic [DLEN-1:0]          vrf_rdata_i,
    output logic                     cmt_valid_o,
    output logic [ReqIdBits-1:0]     cmt_reqid_o
);

    localparam int unsigned IdxBits = $clog2(Depth);

    logic [IdxBits-1:0]  enq_val;
    logic [IdxBits-1:0]  deq_val;
    logic                enq_flag;
    logic                deq_flag;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [LaneBits-1:0] rx_bits;
    logic [LaneBits-1:0] mem_q [Depth];
    lane_beat_t          head;
    head_class_e         head_cls;

    // FIFO occupancy from pointer equality and wrap-flag comparison.
    assign full       = (enq_val == deq_val) && (enq_flag != deq_flag);
    assign empty      = (enq_val == deq_val) && (enq_flag == deq_flag);
    assign rx_ready_o = !full;
    assign push       = rx_valid_i && !full;
    assign rx_bits    = LaneBits'(rx_i);
    assign head       = lane_beat_t'(mem_q[deq_val]);
    assign head_cls   = classify_head(head.nbe);

    CircularQueuePtrTemplate #(.ENTRIES(Depth)) u_enq_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .incr_i  (push),
        .value_o (enq_val),
        .flag_o  (enq_flag)
    );

    CircularQueuePtrTemplate #(.ENTRIES(Depth)) u_deq_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .incr_i  (pop),
        .value_o (deq_val),
        .flag_o  (deq_flag)
    );

    // Payload storage; contents are never observed while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[enq_val] <= rx_bits;
        end
    end

`ifdef VLSU_LOAD_RMW_EN
    ld_state_e       state_q;
    ld_state_e       state_d;
    logic [DLEN-1:0] merge_q;
    logic [DLEN-1:0] merge_d;

    // Write-back FSM state and merged RMW data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end
`else
    // Read response is not consumed when PART beats are written directly.
    logic unused_rd;
    assign unused_rd = ^{vrf_rvalid_i, vrf_rdata_i};
`endif

    // Head dispatch: VRF request, pop, and retire pulse.
    always_comb begin
        pop             = 1'b0;
        vrf_req_valid_o = 1'b0;
        vrf_req_we_o    = 1'b0;
        vrf_req_set_o   = '0;
        vrf_req_bank_o  = '0;
        vrf_req_wdata_o = '0;
        vrf_req_be_o    = '0;
`ifdef VLSU_LOAD_RMW_EN
        state_d = state_q;
        merge_d = merge_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    case (head_cls)
                        CLS_NULL: pop = 1'b1;
                        CLS_FULL: begin
                            vrf_req_valid_o = 1'b1;
                            vrf_req_we_o    = 1'b1;
                            vrf_req_set_o   = head.vaddr_set;
                            vrf_req_bank_o  = head.vaddr_bank;
                            vrf_req_wdata_o = head.data;
                            vrf_req_be_o    = be_all(head.nbe);
                            pop             = vrf_req_ready_i;
                        end
                        CLS_PART: begin
                            vrf_req_valid_o = 1'b1;
                            vrf_req_set_o   = head.vaddr_set;
                            vrf_req_bank_o  = head.vaddr_bank;
                            if (vrf_req_ready_i) begin
                                state_d = RD_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RD_WAIT: begin
                if (vrf_rvalid_i) begin
                    merge_d = merge_nibbles(head.nbe, head.data, vrf_rdata_i);
                    state_d = WR;
                end
            end
            WR: begin
                vrf_req_valid_o = 1'b1;
                vrf_req_we_o    = 1'b1;
                vrf_req_set_o   = head.vaddr_set;
                vrf_req_bank_o  = head.vaddr_bank;
                vrf_req_wdata_o = merge_q;
                vrf_req_be_o    = be_any(head.nbe);
                if (vrf_req_ready_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        if (!empty) begin
            if (head_cls == CLS_NULL) begin
                pop = 1'b1;
            end else begin
                // FULL and PART both write directly; any-nibble equals
                // both-nibble enables for FULL beats.
                vrf_req_valid_o = 1'b1;
                vrf_req_we_o    = 1'b1;
                vrf_req_set_o   = head.vaddr_set;
                vrf_req_bank_o  = head.vaddr_bank;
                vrf_req_wdata_o = head.data;
                vrf_req_be_o    = be_any(head.nbe);
                pop             = vrf_req_ready_i;
            end
        end
`endif
        cmt_valid_o = pop;
        cmt_reqid_o = pop ? head.req_id : '0;
    end

endmodule

// File: tb/tb_vlane_load_wb.sv
`timescale 1ns/1ps
module tb_vlane_load_wb;
    import vlsu_pkg::*;

    typedef struct {
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [11:0] addr;
    } wr_exp_t;

    typedef struct {
        logic [15:0] nbe;
        logic [63:0] data;
        logic [63:0] rdata;
        logic [3:0]  reqid;
        logic        wr;
        logic        rd;
        logic [7:0]  be;
        logic [63:0] wdata;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     rx_valid;
    logic                     rx_ready;
    lane_beat_t               rx;
    logic                     vrf_req_valid;
    logic                     vrf_req_ready;
    logic                     vrf_req_we;
    logic [VAddrSetBits-1:0]  vrf_req_set;
    logic [VAddrBankBits-1:0] vrf_req_bank;
    logic [DLEN-1:0]          vrf_req_wdata;
    logic [BeBits-1:0]        vrf_req_be;
    logic                     vrf_rvalid;
    logic [DLEN-1:0]          vrf_rdata;
    logic                     cmt_valid;
    logic [ReqIdBits-1:0]     cmt_reqid;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_wr     = 0;
    int          n_rd     = 0;
    int          n_cmt    = 0;
    logic        mon_en    = 1'b0;
    logic        rd_seen   = 1'b0;
    logic        auto_resp = 1'b1;
    logic [63:0] cur_rdata = '0;
    wr_exp_t     exp_wr_q[$];
    logic [11:0] exp_rd_q[$];
    logic [3:0]  exp_cmt_q[$];
    vec_t        vec [8];
    wr_exp_t     mon_e;
    logic [11:0] mon_a;
    logic [11:0] addr_v;
    int          base_cmt;
    int          base_wr;
    int          base_rd;

    vlane_load_wb #(.Depth(2), .tx_lane_t(lane_beat_t)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rx_valid_i      (rx_valid),
        .rx_ready_o      (rx_ready),
        .rx_i            (rx),
        .vrf_req_valid_o (vrf_req_valid),
        .vrf_req_ready_i (vrf_req_ready),
        .vrf_req_we_o    (vrf_req_we),
        .vrf_req_set_o   (vrf_req_set),
        .vrf_req_bank_o  (vrf_req_bank),
        .vrf_req_wdata_o (vrf_req_wdata),
        .vrf_req_be_o    (vrf_req_be),
        .vrf_rvalid_i    (vrf_rvalid),
        .vrf_rdata_i     (vrf_rdata),
        .cmt_valid_o     (cmt_valid),
        .cmt_reqid_o     (cmt_reqid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_rx_ready"}, 64'(rx_ready), 64'd1);
        chk({name, "_req_valid"}, 64'(vrf_req_valid), 64'd0);
        chk({name, "_we"}, 64'(vrf_req_we), 64'd0);
        chk({name, "_addr"}, 64'({vrf_req_set, vrf_req_bank}), 64'd0);
        chk({name, "_wdata"}, vrf_req_wdata, 64'd0);
        chk({name, "_be"}, 64'(vrf_req_be), 64'd0);
        chk({name, "_cmt_valid"}, 64'(cmt_valid), 64'd0);
        chk({name, "_cmt_reqid"}, 64'(cmt_reqid), 64'd0);
    endtask

    function automatic lane_beat_t mk_beat(input logic [3:0] id, input logic [11:0] addr,
                                           input logic [15:0] nbe, input logic [63:0] data);
        lane_beat_t b;
        b.req_id     = id;
        b.vaddr_set  = addr[11:2];
        b.vaddr_bank = addr[1:0];
        b.data       = data;
        b.nbe        = nbe;
        return b;
    endfunction

    task automatic expect_beat(input logic [3:0] id, input logic [11:0] addr, input logic wr,
                               input logic rd, input logic [7:0] be, input logic [63:0] wdata);
        wr_exp_t e;
        exp_cmt_q.push_back(id);
        if (wr) begin
            e.wdata = wdata;
            e.be    = be;
            e.addr  = addr;
            exp_wr_q.push_back(e);
        end
        if (rd) exp_rd_q.push_back(addr);
    endtask

    task automatic send_beat(input lane_beat_t b, input string name);
        logic acc;
        int   t;
        acc      = 1'b0;
        t        = 0;
        rx       = b;
        rx_valid = 1'b1;
        while (!acc && t < 60) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            t++;
        end
        rx_valid = 1'b0;
        chk(name, 64'(acc), 64'd1);
    endtask

    task automatic wait_cmt(input int target, input string name);
        int t;
        t = 0;
        while (n_cmt < target && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, 64'(n_cmt), 64'(target));
    endtask

    task automatic setv(input int i, input logic [15:0] nbe, input logic [63:0] data,
                        input logic [63:0] rdata, input logic [3:0] reqid, input logic wr,
                        input logic rd, input logic [7:0] be, input logic [63:0] wdata);
        vec[i].nbe   = nbe;
        vec[i].data  = data;
        vec[i].rdata = rdata;
        vec[i].reqid = reqid;
        vec[i].wr    = wr;
        vec[i].rd    = rd;
        vec[i].be    = be;
        vec[i].wdata = wdata;
    endtask

    // Scoreboard: compare every VRF handshake and retire pulse.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (vrf_req_valid) begin
`ifndef VLSU_LOAD_RMW_EN
                chk("we_never_0", 64'(vrf_req_we), 64'd1);
`endif
                if (vrf_req_ready && vrf_req_we) begin
                    n_wr++;
                    n_checks++;
                    if (exp_wr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_write: actual wdata %h be %h required none", vrf_req_wdata, vrf_req_be);
                    end else begin
                        mon_e = exp_wr_q.pop_front();
                        chk("wr_wdata", vrf_req_wdata, mon_e.wdata);
                        chk("wr_be", 64'(vrf_req_be), 64'(mon_e.be));
                        chk("wr_addr", 64'({vrf_req_set, vrf_req_bank}), 64'(mon_e.addr));
                    end
                end else if (vrf_req_ready && !vrf_req_we) begin
                    n_rd++;
                    rd_seen = 1'b1;
                    chk("rd_be_zero", 64'(vrf_req_be), 64'd0);
                    n_checks++;
                    if (exp_rd_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_read: actual addr %h required none", {vrf_req_set, vrf_req_bank});
                    end else begin
                        mon_a = exp_rd_q.pop_front();
                        chk("rd_addr", 64'({vrf_req_set, vrf_req_bank}), 64'(mon_a));
                    end
                end
            end
            if (cmt_valid) begin
                n_cmt++;
                n_checks++;
                if (exp_cmt_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_cmt: actual reqid %h required none", cmt_reqid);
                end else begin
                    chk("cmt_reqid", 64'(cmt_reqid), 64'(exp_cmt_q.pop_front()));
                end
            end else begin
                chk("cmt_reqid_idle", 64'(cmt_reqid), 64'd0);
            end
        end
    end

    // VRF read responder with 1..3 cycle latency.
    initial begin
        vrf_rvalid = 1'b0;
        vrf_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_seen) begin
                rd_seen = 1'b0;
                if (auto_resp) begin
                    repeat (int'($urandom_range(2, 0))) begin
                        @(posedge clk);
                        #1;
                    end
                    vrf_rvalid = 1'b1;
                    vrf_rdata  = cur_rdata;
                    @(posedge clk);
                    #1;
                    vrf_rvalid = 1'b0;
                    vrf_rdata  = '0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        rx_valid      = 1'b0;
        rx            = '0;
        vrf_req_ready = 1'b1;

        setv(0, 16'hFFFF, 64'h0123_4567_89AB_CDEF, 64'h0, 4'd1, 1'b1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
`ifdef VLSU_LOAD_RMW_EN
        setv(1, 16'h0001, 64'h5555_5555_5555_555A, 64'h1111_1111_1111_1111, 4'd2, 1'b1, 1'b1, 8'h01, 64'h1111_1111_1111_111A);
        setv(5, 16'h8001, 64'hC000_0000_0000_0007, 64'h2222_3333_4444_5555, 4'd6, 1'b1, 1'b1, 8'h81, 64'hC222_3333_4444_5557);
        setv(6, 16'h0006, 64'h7777_7777_7777_7AB7, 64'h0123_4567_89AB_CDEF, 4'd7, 1'b1, 1'b1, 8'h03, 64'h0123_4567_89AB_CABF);
`else
        setv(1, 16'h0001, 64'h5555_5555_5555_555A, 64'h1111_1111_1111_1111, 4'd2, 1'b1, 1'b0, 8'h01, 64'h5555_5555_5555_555A);
        setv(5, 16'h8001, 64'hC000_0000_0000_0007, 64'h2222_3333_4444_5555, 4'd6, 1'b1, 1'b0, 8'h81, 64'hC000_0000_0000_0007);
        setv(6, 16'h0006, 64'h7777_7777_7777_7AB7, 64'h0123_4567_89AB_CDEF, 4'd7, 1'b1, 1'b0, 8'h03, 64'h7777_7777_7777_7AB7);
`endif
        setv(2, 16'h0000, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 4'd3, 1'b0, 1'b0, 8'h00, 64'h0);
        setv(3, 16'h00FF, 64'hFEDC_BA98_7654_3210, 64'h0, 4'd4, 1'b1, 1'b0, 8'h0F, 64'hFEDC_BA98_7654_3210);
        setv(4, 16'h0F0F, 64'h0011_2233_4455_6677, 64'h0, 4'd5, 1'b1, 1'b0, 8'h33, 64'h0011_2233_4455_6677);
        setv(7, 16'hFFFF, 64'hFFFF_0000_AAAA_5555, 64'h0, 4'd15, 1'b1, 1'b0, 8'hFF, 64'hFFFF_0000_AAAA_5555);

        repeat (2) @(posedge clk);
        #1;
        check_idle("rst_held");
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check_idle("post_rst");

        // Table-driven single beats.
        for (int i = 0; i < 8; i++) begin
            addr_v    = 12'(i * 37 + 5);
            cur_rdata = vec[i].rdata;
            base_cmt  = n_cmt;
            expect_beat(vec[i].reqid, addr_v, vec[i].wr, vec[i].rd, vec[i].be, vec[i].wdata);
            send_beat(mk_beat(vec[i].reqid, addr_v, vec[i].nbe, vec[i].data), "vec_accept");
            wait_cmt(base_cmt + 1, "vec_cmt");
        end

        // FULL beat writes in the cycle it reaches the head.
        expect_beat(4'd12, 12'hABC, 1'b1, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        send_beat(mk_beat(4'd12, 12'hABC, 16'hFFFF, 64'h0123_4567_89AB_CDEF), "full_accept");
        @(negedge clk);
        chk("full_same_cycle_valid", 64'(vrf_req_valid), 64'd1);
        chk("full_same_cycle_we", 64'(vrf_req_we), 64'd1);
        chk("full_same_cycle_cmt", 64'(cmt_valid), 64'd1);
        chk("full_same_cycle_reqid", 64'(cmt_reqid), 64'd12);
        @(posedge clk);
        #1;

        // NULL beat retires with no request in the cycle it reaches the head.
        expect_beat(4'd8, 12'h123, 1'b0, 1'b0, 8'h00, 64'h0);
        send_beat(mk_beat(4'd8, 12'h123, 16'h0000, 64'hCAFE_F00D_CAFE_F00D), "null_accept");
        @(negedge clk);
        chk("null_cmt_same_cycle", 64'(cmt_valid), 64'd1);
        chk("null_no_req", 64'(vrf_req_valid), 64'd0);
        @(posedge clk);
        #1;

        // Stray read data while idle must not disturb the next beat.
        vrf_rvalid = 1'b1;
        vrf_rdata  = '1;
        @(negedge clk);
        chk("stray_rvalid_no_req", 64'(vrf_req_valid), 64'd0);
        @(posedge clk);
        #1;
        vrf_rvalid = 1'b0;
        vrf_rdata  = '0;
        base_cmt   = n_cmt;
        expect_beat(4'd13, 12'h0F0, 1'b1, 1'b0, 8'hFF, 64'h1357_9BDF_0246_8ACE);
        send_beat(mk_beat(4'd13, 12'h0F0, 16'hFFFF, 64'h1357_9BDF_0246_8ACE), "stray_accept");
        wait_cmt(base_cmt + 1, "stray_cmt");

        // Back-to-back FULL beats: one write per cycle.
        base_wr  = n_wr;
        base_cmt = n_cmt;
        for (int i = 0; i < 4; i++) begin
            addr_v = 12'(100 + i);
            expect_beat(4'(i), addr_v, 1'b1, 1'b0, 8'hFF, {32'hA5A5_0000, 32'(i)});
            send_beat(mk_beat(4'(i), addr_v, 16'hFFFF, {32'hA5A5_0000, 32'(i)}), "b2b_accept");
        end
        @(posedge clk);
        #1;
        chk("b2b_one_per_cycle", 64'(n_wr - base_wr), 64'd4);
        wait_cmt(base_cmt + 4, "b2b_cmt");

        // Depth-2 backpressure, stable request, in-order drain.
        vrf_req_ready = 1'b0;
        base_cmt      = n_cmt;
        expect_beat(4'd9, 12'h201, 1'b1, 1'b0, 8'hFF, 64'h9999_0000_9999_0001);
        expect_beat(4'd10, 12'h202, 1'b1, 1'b0, 8'hF0, 64'hAAAA_0000_AAAA_0002);
        expect_beat(4'd11, 12'h203, 1'b1, 1'b0, 8'hFF, 64'hBBBB_0000_BBBB_0003);
        send_beat(mk_beat(4'd9, 12'h201, 16'hFFFF, 64'h9999_0000_9999_0001), "stall_a");
        send_beat(mk_beat(4'd10, 12'h202, 16'hFF00, 64'hAAAA_0000_AAAA_0002), "stall_b");
        rx       = mk_beat(4'd11, 12'h203, 16'hFFFF, 64'hBBBB_0000_BBBB_0003);
        rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rx_ready_low", 64'(rx_ready), 64'd0);
            chk("stall_req_valid", 64'(vrf_req_valid), 64'd1);
            chk("stall_wdata_stable", vrf_req_wdata, 64'h9999_0000_9999_0001);
            chk("stall_addr_stable", 64'({vrf_req_set, vrf_req_bank}), 64'h201);
        end
        @(posedge clk);
        #1;
        vrf_req_ready = 1'b1;
        send_beat(mk_beat(4'd11, 12'h203, 16'hFFFF, 64'hBBBB_0000_BBBB_0003), "stall_c");
        wait_cmt(base_cmt + 3, "stall_drain_cmt");

        // Reset with a loaded FIFO empties it and retires nothing.
        vrf_req_ready = 1'b0;
        send_beat(mk_beat(4'd1, 12'h301, 16'hFFFF, 64'h1), "rst_fill_a");
        send_beat(mk_beat(4'd2, 12'h302, 16'hFFFF, 64'h2), "rst_fill_b");
        chk("rst_fill_full", 64'(rx_ready), 64'd0);
        base_wr  = n_wr;
        base_cmt = n_cmt;
        rst      = 1'b1;
        #1;
        check_idle("rst_async");
        @(posedge clk);
        #1;
        rst           = 1'b0;
        vrf_req_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_fifo_no_write", 64'(n_wr), 64'(base_wr));
        chk("rst_fifo_no_cmt", 64'(n_cmt), 64'(base_cmt));
        chk("rst_fifo_empty", 64'(vrf_req_valid), 64'd0);
        chk("rst_fifo_ready", 64'(rx_ready), 64'd1);

`ifdef VLSU_LOAD_RMW_EN
        // Reset while waiting for read data abandons the beat.
        auto_resp = 1'b0;
        base_wr   = n_wr;
        base_cmt  = n_cmt;
        base_rd   = n_rd;
        exp_rd_q.push_back(12'h3F1);
        send_beat(mk_beat(4'd14, 12'h3F1, 16'h0001, 64'hA), "rdwait_accept");
        @(posedge clk);
        #1;
        chk("rdwait_read_issued", 64'(n_rd), 64'(base_rd + 1));
        chk("rdwait_req_low", 64'(vrf_req_valid), 64'd0);
        rst = 1'b1;
        #1;
        check_idle("rst_in_rd_wait");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        vrf_rvalid = 1'b1;
        vrf_rdata  = 64'h1111_1111_1111_1111;
        @(posedge clk);
        #1;
        vrf_rvalid = 1'b0;
        vrf_rdata  = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rdwait_no_write", 64'(n_wr), 64'(base_wr));
        chk("rdwait_no_cmt", 64'(n_cmt), 64'(base_cmt));
        chk("rdwait_fifo_empty", 64'(vrf_req_valid), 64'd0);
        rd_seen   = 1'b0;
        auto_resp = 1'b1;
`endif

        chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
        chk("cmt_queue_drained", 64'(exp_cmt_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
